// File: rtl/riscv_regfile_dump.sv
// RISC-V style register file (x0 hardwired to zero) with NRD combinational read ports
// and a ready/valid dump streamer. Optional write-to-read bypass: define REGFILE_BYPASS_EN.
module riscv_regfile_dump #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]             rd_data,
  input  logic                            we,
  input  logic [$clog2(NREGS)-1:0]        wr_addr,
  input  logic [XLEN-1:0]                 wr_data,
  input  logic                            dump_req,
  output logic                            dump_valid,
  input  logic                            dump_ready,
  output logic [$clog2(NREGS)-1:0]        dump_addr,
  output logic [XLEN-1:0]                 dump_data,
  output logic                            dump_busy,
  output logic                            dump_done
);

  localparam int ADDR_W = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  logic [XLEN-1:0]   regs_q [NREGS];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic              wr_hit;
  logic [ADDR_W-1:0] load_addr;
  logic [XLEN-1:0]   load_val;

  assign wr_hit = we && (wr_addr != '0);

  // Entry 0 is only ever cleared, so it stays constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [XLEN-1:0]   stored;
      assign ra     = rd_addr[gi*ADDR_W +: ADDR_W];
      assign stored = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
      assign rd_data[gi*XLEN +: XLEN] = (wr_hit && (wr_addr == ra)) ? wr_data : stored;
`else
      assign rd_data[gi*XLEN +: XLEN] = stored;
`endif
    end
  endgenerate

  // The beat being loaded must see a write landing on the same edge.
  assign load_addr = (state_q == S_STREAM) ? idx_q + 1'b1 : '0;
  assign load_val  = (wr_hit && (wr_addr == load_addr)) ? wr_data : regs_q[load_addr];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          state_d = S_STREAM;
          idx_d   = '0;
          data_d  = load_val;
        end
      end
      S_STREAM: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = load_val;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = (state_q == S_STREAM);
  assign dump_busy  = (state_q != S_IDLE);
  assign dump_done  = (state_q == S_DONE);
  assign dump_addr  = idx_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_riscv_regfile_dump.sv
// Self-checking bench for riscv_regfile_dump: vector table, directed dump scenarios and a
// randomized phase, all checked against a transaction-level model of the register file and dump stream.
module tb_riscv_regfile_dump;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic                 we;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 dump_req;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [AW-1:0]        dump_addr;
  logic [XLEN-1:0]      dump_data;
  logic                 dump_busy;
  logic                 dump_done;

  riscv_regfile_dump #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents plus the beat currently on offer (-1 = none).
  logic [XLEN-1:0] m_regs [NREGS];
  int              m_beat;
  logic [XLEN-1:0] m_beat_val;
  bit              m_done;
  int              m_hs;

  typedef struct {
    bit          w;
    int          wa;
    logic [31:0] wd;
    int          ra0;
    int          ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_beat = -1;
    m_beat_val = '0;
    m_done = 1'b0;
    m_hs = 0;
  endtask

  task automatic set_in(input bit w, input int wa, input logic [31:0] wd,
                        input int ra0, input int ra1, input bit req, input bit rdy);
    we         = w;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    rd_addr    = {AW'(ra1), AW'(ra0)};
    dump_req   = req;
    dump_ready = rdy;
  endtask

  function automatic logic [XLEN-1:0] exp_read(input int a);
    if (a == 0) return '0;
    if (BYP && we && (int'(wr_addr) == a)) return wr_data;
    return m_regs[a];
  endfunction

  task automatic check_reads();
    for (int k = 0; k < NRD; k++)
      chk($sformatf("rd_port%0d addr %0d", k, rd_addr[k*AW +: AW]),
          rd_data[k*XLEN +: XLEN], exp_read(int'(rd_addr[k*AW +: AW])));
  endtask

  // Advance one edge, update the model from the sampled inputs, then check the dump outputs.
  task automatic tick();
    bit hs;
    bit prev_done;
    @(posedge clk);
    hs = (m_beat >= 0) && dump_ready;
    if (hs) $display("[TB] beat addr=%0d data=0x%0h", m_beat, m_beat_val);
    if (we && (wr_addr != '0)) m_regs[wr_addr] = wr_data;
    prev_done = m_done;
    m_done = 1'b0;
    if (m_beat < 0 && !prev_done) begin
      if (dump_req) begin
        m_beat = 0;
        m_beat_val = m_regs[0];
        m_hs = 0;
      end
    end else if (hs) begin
      m_hs++;
      if (m_beat == NREGS - 1) begin
        m_beat = -1;
        m_done = 1'b1;
        chk("beats_per_dump", m_hs, NREGS);
      end else begin
        m_beat++;
        m_beat_val = m_regs[m_beat];
      end
    end
    #1;
    chk("dump_valid", dump_valid, m_beat >= 0);
    chk("dump_busy", dump_busy, (m_beat >= 0) || m_done);
    chk("dump_done", dump_done, m_done);
    if (m_beat >= 0) begin
      chk("dump_addr", dump_addr, m_beat);
      chk("dump_data", dump_data, m_beat_val);
    end
  endtask

  task automatic cycle(input bit w, input int wa, input logic [31:0] wd,
                       input int ra0, input int ra1, input bit req, input bit rdy);
    set_in(w, wa, wd, ra0, ra1, req, rdy);
    #1;
    check_reads();
    tick();
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 0, 32'd0, $urandom_range(0, NREGS-1), $urandom_range(0, NREGS-1), 1'b0, rdy);
  endtask

  // Expects rst held high by the caller for the whole call.
  task automatic reset_checks(input string tag);
    chk({tag, " valid"}, dump_valid, 1'b0);
    chk({tag, " busy"}, dump_busy, 1'b0);
    chk({tag, " done"}, dump_done, 1'b0);
    chk({tag, " addr"}, dump_addr, '0);
    chk({tag, " data"}, dump_data, '0);
    for (int a = 0; a < NREGS; a++) begin
      set_in(1'b0, 0, 32'd0, a, NREGS-1-a, 1'b0, 1'b0);
      #1;
      chk($sformatf("%s reg%0d", tag, a), rd_data[XLEN-1:0], '0);
      chk($sformatf("%s no_done", tag), dump_done, 1'b0);
    end
    $display("[TB] %s reset state checked", tag);
  endtask

  initial begin
    int lat;
    bit wrote, done_seen, seen7;

    rst = 1'b1;
    set_in(1'b0, 0, 32'd0, 0, 0, 1'b0, 1'b0);
    model_reset();
    #3;
    reset_checks("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic write/read vectors; expected values are the pre-edge reads.
    vt[0] = '{1'b1, 1, 32'd5,       3, 1, 32'd0,  BYP ? 32'd5  : 32'd0};
    vt[1] = '{1'b1, 2, 32'd10,      1, 2, 32'd5,  BYP ? 32'd10 : 32'd0};
    vt[2] = '{1'b1, 3, 32'd15,      3, 1, BYP ? 32'd15 : 32'd0, 32'd5};
    vt[3] = '{1'b1, 0, 32'hDEAD,    3, 0, 32'd15, 32'd0};
    vt[4] = '{1'b0, 0, 32'd0,       3, 1, 32'd15, 32'd5};
    vt[5] = '{1'b1, 4, 32'h1234,    4, 0, BYP ? 32'h1234 : 32'd0, 32'd0};
    vt[6] = '{1'b0, 0, 32'd0,       4, 2, 32'h1234, 32'd10};
    for (int i = 0; i < 7; i++) begin
      set_in(vt[i].w, vt[i].wa, vt[i].wd, vt[i].ra0, vt[i].ra1, 1'b0, 1'b0);
      #1;
      chk($sformatf("vec%0d port0", i), rd_data[XLEN-1:0], vt[i].e0);
      chk($sformatf("vec%0d port1", i), rd_data[2*XLEN-1:XLEN], vt[i].e1);
      $display("[TB] vec%0d we=%0d wa=%0d wd=0x%0h rd0=0x%0h rd1=0x%0h", i, vt[i].w,
               vt[i].wa, vt[i].wd, rd_data[XLEN-1:0], rd_data[2*XLEN-1:XLEN]);
      tick();
    end

    // Preload xi = i, then a full-speed dump.
    for (int i = 1; i < NREGS; i++)
      cycle(1'b1, i, i, $urandom_range(0, NREGS-1), i, 1'b0, 1'b0);
    cycle(1'b0, 0, 32'd0, 0, 0, 1'b1, 1'b1);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (dump_done) begin
        lat = n;
        break;
      end
      idle(1'b1);
    end
    chk("dump_latency", lat, 33);
    idle(1'b0);
    idle(1'b0);

    // Toggling ready; write x7 while beat 7 is stalled.
    cycle(1'b0, 0, 32'd0, 0, 0, 1'b1, 1'b0);
    wrote = 1'b0; done_seen = 1'b0; seen7 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bit rdy, w;
      if (dump_done) begin
        done_seen = 1'b1;
        break;
      end
      rdy = c[0];
      w = !wrote && dump_valid && (dump_addr == 5'd7) && !rdy;
      if (w) wrote = 1'b1;
      if (dump_valid && dump_addr == 5'd7 && rdy && !seen7) begin
        seen7 = 1'b1;
        chk("beat7_keeps_old", dump_data, 32'd7);
      end
      cycle(w, 7, 32'hAA, $urandom_range(0, NREGS-1), 7, 1'b0, rdy);
    end
    chk("toggle_dump_done", done_seen, 1'b1);
    chk("beat7_write_issued", wrote, 1'b1);
    set_in(1'b0, 0, 32'd0, 7, 0, 1'b0, 1'b0);
    #1;
    chk("x7_after_write", rd_data[XLEN-1:0], 32'hAA);
    idle(1'b0);

    // Write x20 at index 10, and re-request mid-dump and during DONE.
    cycle(1'b0, 0, 32'd0, 0, 0, 1'b1, 1'b1);
    done_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bit w, req;
      if (dump_done) begin
        done_seen = 1'b1;
        break;
      end
      w   = dump_valid && (dump_addr == 5'd10);
      req = dump_valid && (dump_addr == 5'd15);
      if (dump_valid && dump_addr == 5'd20) chk("beat20_new_value", dump_data, 32'h55);
      cycle(w, 20, 32'h55, 20, 10, req, 1'b1);
    end
    chk("write_dump_done", done_seen, 1'b1);
    cycle(1'b0, 0, 32'd0, 0, 0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("no_second_dump", dump_busy, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, NREGS-1), $urandom,
            $urandom_range(0, NREGS-1), $urandom_range(0, NREGS-1),
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    for (int c = 0; c < 80 && dump_busy; c++) idle(1'b1);
    chk("random_phase_drained", dump_busy, 1'b0);

    // Reset while beat 12 is on offer.
    cycle(1'b0, 0, 32'd0, 0, 0, 1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (dump_valid && dump_addr == 5'd12) break;
      idle(1'b1);
    end
    chk("reached_beat12", dump_addr, 5'd12);
    rst = 1'b1;
    #1;
    chk("abort valid", dump_valid, 1'b0);
    chk("abort busy", dump_busy, 1'b0);
    chk("abort data", dump_data, '0);
    model_reset();
    reset_checks("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1'b0);
    idle(1'b0);
    cycle(1'b0, 0, 32'd0, 0, 0, 1'b1, 1'b0);
    chk("restart valid", dump_valid, 1'b1);
    chk("restart addr", dump_addr, '0);
    chk("restart data", dump_data, '0);
    done_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (dump_done) begin
        done_seen = 1'b1;
        break;
      end
      idle(1'b1);
    end
    chk("restart_dump_done", done_seen, 1'b1);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_regfile_dump.md
RISCV_REGFILE_DUMP -- requirements
Module: riscv_regfile_dump

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: number of registers, power of two, at least 4.
REQ-003 SHALL have parameter NRD, default 2: number of independent read ports, at least 1.
REQ-004 SHALL derive ADDR_W = $clog2(NREGS) as a localparam.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port rd_addr, input, NRD*ADDR_W: packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data, output, NRD*XLEN: packed read data, same packing.
REQ-009 SHALL have port we, input, 1: write enable.
REQ-010 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-011 SHALL have port wr_data, input, XLEN: write data.
REQ-012 SHALL have port dump_req, input, 1: single-cycle request to stream out all registers.
REQ-013 SHALL have port dump_valid, output, 1: dump beat valid.
REQ-014 SHALL have port dump_ready, input, 1: consumer accepts beat.
REQ-015 SHALL have port dump_addr, output, ADDR_W: index of current beat.
REQ-016 SHALL have port dump_data, output, XLEN: contents of current beat.
REQ-017 SHALL have port dump_busy, output, 1: FSM is not in IDLE.
REQ-018 SHALL have port dump_done, output, 1: one-cycle pulse after the last beat.

Function
REQ-019 SHALL hardwire register 0 to zero; writes to address 0 are discarded, and reads of address 0 return 0.
REQ-020 SHALL make reads combinational on every port, independent of the other ports and of the dump FSM.
REQ-021 SHALL write wr_data into wr_addr on the rising edge when we=1 and wr_addr!=0.
REQ-022 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-023 In IDLE, dump_req=1 SHALL transition to STREAM on the next edge, load index=0, and register dump_data = regfile[0].
REQ-024 In STREAM, dump_valid SHALL be 1, dump_addr SHALL equal index, and dump_data SHALL hold its registered value.
REQ-025 While in STREAM, dump_data and dump_addr SHALL remain stable while dump_ready=0, including when a write hits the current index.
REQ-026 On dump_valid & dump_ready with index<NREGS-1, the block SHALL increment index and load dump_data = regfile[index+1], including the effect of any write on that same edge under REQ-030 rules.
REQ-027 On a handshake with index=NREGS-1, the FSM SHALL go to DONE; DONE SHALL last exactly one cycle with dump_done=1, then return to IDLE.
REQ-028 dump_req SHALL be ignored in STREAM and DONE (no queuing).
REQ-029 dump_busy SHALL be 1 in STREAM and DONE; dump_valid SHALL be 0 outside STREAM.
REQ-030 A dump beat loaded on the same edge as a write to its address SHALL carry the newly written value.
REQ-031 Normal writes SHALL proceed during a dump; a dump SHALL take at least NREGS+1 cycles from request to dump_done.

Reset
REQ-032 While rst=1, all registers SHALL be 0, the FSM SHALL be in IDLE, index SHALL be 0, and dump_valid, dump_busy, dump_done, dump_addr and dump_data SHALL be 0.
REQ-033 rst asserted mid-dump SHALL abort the dump immediately, with no dump_done pulse; a new dump_req after release SHALL start from index 0.

Configuration
REQ-034 Macro REGFILE_BYPASS_EN, when defined: a read port SHALL return wr_data combinationally when we=1, wr_addr!=0 and rd_addr==wr_addr.
REQ-035 Without REGFILE_BYPASS_EN: such a read SHALL return the old stored value until after the edge.
REQ-036 REGFILE_BYPASS_EN SHALL NOT affect the dump path or register 0.

Verification
REQ-037 Reset, then write x1=5, x2=10, x3=15 on consecutive edges -> port0 rd_addr=3 reads 15; port1 rd_addr=1 reads 5; write of 0xDEAD to x0 -> reads 0.
REQ-038 Same-cycle write x4=0x1234 with rd_addr=4 before the edge -> 0x1234 with REGFILE_BYPASS_EN, previous value 0 without.
REQ-039 Preload xi=i for all i; pulse dump_req with dump_ready=1 -> 32 beats, addr 0..31 with data 0..31, dump_done exactly once at cycle 33 after request.
REQ-040 Dump with dump_ready toggling 1/0 every cycle and a write x7=0xAA while beat 7 is stalled -> beat 7 keeps its old value; no beat is lost or duplicated.
REQ-041 Write x20=0x55 while the dump is at index 10 -> beat 20 carries 0x55; a dump_req pulsed during the dump -> no second dump starts.
REQ-042 Assert rst at beat 12 -> dump_valid, dump_busy, dump_data = 0 within the reset cycle, all registers read 0, no dump_done; a fresh dump_req restarts at addr 0.
